shift_add_mult_ctrl: RTL and testbench

- Sequential unsigned N×N multiplier controller.
- Time-multiplexes a single nAdder instance over N shift-and-add iterations instead of using an array of adders.
- Sits beside the arithmetic datapath. The host issues one multiply per start/done handshake.
- Trades N+2 cycles of latency for one N-bit ripple adder.

---
 rtl/shift_add_mult_pkg.sv | 22 ++
 rtl/shift_add_mult_ctrl_nadder.sv | 37 +++
 rtl/shift_add_mult_ctrl.sv | 103 ++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared state encoding and sizing helper for the shift-and-add multiplier controller.
package shift_add_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_nadder.sv
// N-bit ripple-carry adder built from single-bit full adders.
module Full_Adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module nAdder #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_s,
  output logic         o_cout
);
  logic [N:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < N; g++) begin : g_fa
    Full_Adder u_fa (
      .i_a   (i_a[g]),
      .i_b   (i_b[g]),
      .i_cin (w_c[g]),
      .o_s   (o_s[g]),
      .o_cout(w_c[g+1])
    );
  end

  assign o_cout = w_c[N];
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned NxN shift-and-add multiplier sharing one nAdder over N iterations.
// Optional macro SHIFT_ADD_MULT_ZERO_BYPASS_EN: zero operands skip straight to DONE.
//
// state  | meaning
// IDLE   | ready for a new operation, product holds last result
// CALC   | one add/shift iteration per cycle, count tracks iteration
// DONE   | one-cycle done pulse, product valid
module shift_add_mult_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int            CW   = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e          r_state, w_state_nxt;
  logic [2*N-1:0]  r_p, w_p_nxt;
  logic [N-1:0]    r_mcand, w_mcand_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [N-1:0]    w_addend;
  logic [N-1:0]    w_sum;
  logic            w_cout;

  assign w_addend = r_p[0] ? r_mcand : '0;

  nAdder #(.N(N)) u_nadder (
    .i_a   (r_p[2*N-1:N]),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_s   (w_sum),
    .o_cout(w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_mcand_nxt = r_mcand;
    w_count_nxt = r_count;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_mcand_nxt = a;
          w_p_nxt     = {{N{1'b0}}, b};
          w_count_nxt = '0;
          w_state_nxt = S_CALC;
`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
          if ((a == '0) || (b == '0)) begin
            w_p_nxt     = '0;
            w_state_nxt = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        busy    = 1'b1;
        // Carry out lands in the top bit; the product never exceeds 2N bits.
        w_p_nxt = {w_cout, w_sum, r_p[N-1:1]};
        if (r_count == LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_mcand <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_mcand <= w_mcand_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign product = r_p;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed and random checks of shift_add_mult_ctrl at N=8 and N=16 with a product scoreboard.
module tb_shift_add_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start8, ready8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        start16, ready16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] product16;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] q8[$];
  logic [31:0] q16[$];
  logic        prev_done8  = 1'b0;
  logic        prev_done16 = 1'b0;
  logic [31:0] ev8, ev16;

  shift_add_mult_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8)
  );

  shift_add_mult_ctrl #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .product(product16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_busy(input int n, input logic [15:0] av, input logic [15:0] bv);
`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
    if (av == 16'd0 || bv == 16'd0) return 0;
`endif
    return n;
  endfunction

  // Issue one multiply, scramble operands after acceptance, wait (bounded) for done.
  task automatic run_op(input bit wide, input logic [15:0] av, input logic [15:0] bv);
    int n;
    int nb;
    bit got;
    logic [15:0] at, bt;
    n  = wide ? 16 : 8;
    at = wide ? av : {8'h00, av[7:0]};
    bt = wide ? bv : {8'h00, bv[7:0]};
    if (wide) begin
      a16 = at; b16 = bt; start16 = 1'b1;
      q16.push_back(32'(at) * 32'(bt));
    end else begin
      a8 = at[7:0]; b8 = bt[7:0]; start8 = 1'b1;
      q8.push_back(32'(at) * 32'(bt));
    end
    tick();
    start8 = 1'b0; start16 = 1'b0;
    a8  = 8'($urandom); b8  = 8'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom);
    nb  = 0;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      if (wide ? busy16 : busy8) nb++;
      if (wide ? done16 : done8) got = 1'b1;
      else tick();
    end
    chk("done_seen", got, 1);
    chk("busy_cycles", nb, exp_busy(n, at, bt));
    tick();
    chk("ready_after_done", wide ? ready16 : ready8, 1);
    chk("done_cleared", wide ? done16 : done8, 0);
  endtask

  always @(negedge clk) begin
    if (done8) begin
      chk("done8_expected", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        ev8 = q8.pop_front();
        chk("product8", product8, ev8);
      end
      chk("done8_width", prev_done8, 0);
    end
    prev_done8 = done8;
    if (done16) begin
      chk("done16_expected", q16.size() > 0, 1);
      if (q16.size() > 0) begin
        ev16 = q16.pop_front();
        chk("product16", product16, ev16);
      end
      chk("done16_width", prev_done16, 0);
    end
    prev_done16 = done16;
  end

  initial begin
    bit saw;
    int phase;
    rst_n = 1'b0; start8 = 1'b1; a8 = 8'd5; b8 = 8'd5;
    start16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) tick();
    chk("rst_ready", ready8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_product", product8, 0);
    chk("rst_ready16", ready16, 1);
    start8 = 1'b0;
    rst_n  = 1'b1;
    tick();
    chk("post_rst_idle", ready8, 1);

    // basic multiply and hold in IDLE
    run_op(1'b0, 16'd13, 16'd11);
    repeat (3) tick();
    chk("hold_idle_product", product8, 143);

    // carry into the top product bit
    run_op(1'b0, 16'd255, 16'd255);

    // start held high: one accept every N+2 cycles
    a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    repeat (3) q8.push_back(32'd15);
    tick();
    for (int e = 0; e < 30; e++) begin
      phase = e % 10;
      chk("held_done", done8, (phase == 8));
      chk("held_busy", busy8, (phase < 8));
      if (phase < 8) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        a8 = 8'd3; b8 = 8'd5;
      end
      if (e == 29) start8 = 1'b0;
      tick();
    end
    chk("held_stopped", busy8, 0);

    // reset after the fourth iteration aborts silently
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_ready", ready8, 1);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_product", product8, 0);
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      saw |= done8;
      tick();
    end
    chk("abort_no_done", saw, 0);
    run_op(1'b0, 16'd7, 16'd6);

    // zero operand
    run_op(1'b0, 16'd0, 16'd200);

    // random sweeps
    for (int i = 0; i < 1000; i++) run_op(1'b0, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 1000; i++) run_op(1'b1, 16'($urandom), 16'($urandom));
    run_op(1'b1, 16'hFFFF, 16'hFFFF);
    run_op(1'b1, 16'd0, 16'd1234);

    tick();
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
